// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcode encodings and the machine word.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br  = 4'b0000,
        op_add = 4'b0001,
        op_ldb = 4'b0010,
        op_stb = 4'b0011,
        op_jsr = 4'b0100,
        op_and = 4'b0101,
        op_ldr = 4'b0110,
        op_str = 4'b0111,
        op_rti = 4'b1000,
        op_not = 4'b1001,
        op_ldi = 4'b1010,
        op_sti = 4'b1011,
        op_jmp = 4'b1100,
        op_shf = 4'b1101,
        op_lea = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef logic [15:0] lc3b_word;

endpackage

// File: rtl/add_alu.sv
// Combinational add-class ALU: add, and, not, shift; other opcodes pass Vk.
module add_alu
    import lc3b_types::*;
#(
    parameter int DATA_W = 16
) (
    input  lc3b_opcode               op,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] y
);

    logic [3:0] amt;

    // Decode the opcode; shift control lives in b[5:4], amount in b[3:0].
    always_comb begin
        amt = b[3:0];
        y   = b;
        case (op)
            op_add: y = a + b;
            op_and: y = a & b;
            op_not: y = ~a;
            op_shf: begin
                if (!b[4])
                    y = a << amt;
                else if (!b[5])
                    y = a >> amt;
                else
                    y = a >>> amt;
            end
            default: y = b;
        endcase
    end

endmodule

// File: rtl/register.sv
// Generic load-enabled register with asynchronous active-high clear.
module register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d when load is asserted, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/add_issue_unit.sv
// Add issue unit: picks the lowest-index ready station, executes it in a
// registered ALU stage and broadcasts the result on the CDB.
module add_issue_unit
    import lc3b_types::*;
#(
    parameter int NUM_RS = 3,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_RS-1:0]          rs_busy,
    input  logic [NUM_RS-1:0]          rs_Vj_valid,
    input  logic [NUM_RS-1:0]          rs_Vk_valid,
    input  logic [NUM_RS*4-1:0]        rs_op,
    input  logic [NUM_RS*DATA_W-1:0]   rs_Vj,
    input  logic [NUM_RS*DATA_W-1:0]   rs_Vk,
    input  logic [NUM_RS*TAG_W-1:0]    rs_dest,
    output logic [NUM_RS-1:0]          rs_clr_busy,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    input  logic                       cdb_grant
);

    localparam int EX_W  = 4 + 2*DATA_W + TAG_W;
    localparam int RES_W = TAG_W + DATA_W;

    // Isolate the lowest set bit: fixed priority toward entry 0.
    function automatic logic [NUM_RS-1:0] prio_sel(input logic [NUM_RS-1:0] r);
        return r & (~r + NUM_RS'(1));
    endfunction

    logic [NUM_RS-1:0]        ready_p0;
    logic [NUM_RS-1:0]        sel_oh_p0;
    logic [3:0]               op_p0;
    logic signed [DATA_W-1:0] vj_p0;
    logic signed [DATA_W-1:0] vk_p0;
    logic [TAG_W-1:0]         dest_p0;
    logic                     dispatch;
    logic                     res_adv;
    logic                     ex_adv;

    logic [EX_W-1:0]          ex_q;
    logic [3:0]               op_raw_p1;
    lc3b_opcode               op_p1;
    logic signed [DATA_W-1:0] vj_p1;
    logic signed [DATA_W-1:0] vk_p1;
    logic [TAG_W-1:0]         dest_p1;
    logic signed [DATA_W-1:0] alu_p1;
    logic                     vld_p1;
    logic                     res_load;
    logic [RES_W-1:0]         res_q;

    // ---- stage p0: station scan and select ----
    assign ready_p0  = rs_busy & rs_Vj_valid & rs_Vk_valid;
    assign sel_oh_p0 = prio_sel(ready_p0);
    assign res_adv   = !cdb_valid || cdb_grant;
    assign ex_adv    = !vld_p1 || res_adv;
    assign dispatch  = ex_adv && (|ready_p0) && !flush;

    assign rs_clr_busy = (rst || !dispatch) ? '0 : sel_oh_p0;

    // One-hot mux of the winning station's fields.
    always_comb begin
        op_p0   = '0;
        vj_p0   = '0;
        vk_p0   = '0;
        dest_p0 = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (sel_oh_p0[i]) begin
                op_p0   = rs_op[4*i +: 4];
                vj_p0   = rs_Vj[DATA_W*i +: DATA_W];
                vk_p0   = rs_Vk[DATA_W*i +: DATA_W];
                dest_p0 = rs_dest[TAG_W*i +: TAG_W];
            end
        end
    end

    // ---- stage p1: exec register and ALU ----
    register #(.WIDTH(EX_W)) ex_reg (
        .clk  (clk),
        .rst  (rst),
        .load (dispatch),
        .d    ({op_p0, vj_p0, vk_p0, dest_p0}),
        .q    (ex_q)
    );

    assign {op_raw_p1, vj_p1, vk_p1, dest_p1} = ex_q;
    assign op_p1 = lc3b_opcode'(op_raw_p1);

    add_alu #(.DATA_W(DATA_W)) alu (
        .op (op_p1),
        .a  (vj_p1),
        .b  (vk_p1),
        .y  (alu_p1)
    );

    // ---- stage p2: result register driving the CDB ----
    assign res_load = res_adv && vld_p1;

    register #(.WIDTH(RES_W)) res_reg (
        .clk  (clk),
        .rst  (rst),
        .load (res_load),
        .d    ({dest_p1, alu_p1}),
        .q    (res_q)
    );

    assign {cdb_tag, cdb_data} = res_q;

    // Valid bits for exec and result stages; flush drops both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            cdb_valid <= 1'b0;
        end else if (flush) begin
            vld_p1    <= 1'b0;
            cdb_valid <= 1'b0;
        end else begin
            if (dispatch)
                vld_p1 <= 1'b1;
            else
                vld_p1 <= vld_p1 && !res_adv;
            if (res_load)
                cdb_valid <= 1'b1;
            else if (cdb_grant)
                cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_issue_unit.sv
// Bench for add_issue_unit: directed scenarios plus random traffic checked
// against a queue-based model of in-flight results.
module tb_add_issue_unit;
    import lc3b_types::*;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int TW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              cdb_grant;
    logic [N-1:0]      rs_busy, rs_Vj_valid, rs_Vk_valid;
    logic [N*4-1:0]    rs_op;
    logic [N*DW-1:0]   rs_Vj, rs_Vk;
    logic [N*TW-1:0]   rs_dest;
    logic [N-1:0]      rs_clr_busy;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_data;

    add_issue_unit #(.NUM_RS(N), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .rs_busy     (rs_busy),
        .rs_Vj_valid (rs_Vj_valid),
        .rs_Vk_valid (rs_Vk_valid),
        .rs_op       (rs_op),
        .rs_Vj       (rs_Vj),
        .rs_Vk       (rs_Vk),
        .rs_dest     (rs_dest),
        .rs_clr_busy (rs_clr_busy),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .cdb_grant   (cdb_grant)
    );

    always #5 clk = ~clk;

    // Station state owned by the bench.
    logic          st_busy [N];
    logic          st_jv   [N];
    logic          st_kv   [N];
    logic [3:0]    st_op   [N];
    logic [DW-1:0] st_vj   [N];
    logic [DW-1:0] st_vk   [N];
    logic [TW-1:0] st_dest [N];

    always_comb begin
        rs_busy = '0; rs_Vj_valid = '0; rs_Vk_valid = '0;
        rs_op = '0; rs_Vj = '0; rs_Vk = '0; rs_dest = '0;
        for (int i = 0; i < N; i++) begin
            rs_busy[i]          = st_busy[i];
            rs_Vj_valid[i]      = st_jv[i];
            rs_Vk_valid[i]      = st_kv[i];
            rs_op[4*i +: 4]     = st_op[i];
            rs_Vj[DW*i +: DW]   = st_vj[i];
            rs_Vk[DW*i +: DW]   = st_vk[i];
            rs_dest[TW*i +: TW] = st_dest[i];
        end
    end

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        int            issue;
    } res_t;

    res_t         q[$];
    int           t = 0;
    int           n_vec = 0;
    int           n_err = 0;
    logic [N-1:0] exp_clr;
    logic         exp_vis;

    function automatic logic [DW-1:0] model_alu(input logic [3:0] op,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [3:0]    amt;
        logic [DW-1:0] r;
        amt = b[3:0];
        if (op == op_add) return a + b;
        if (op == op_and) return a & b;
        if (op == op_not) return ~a;
        if (op == op_shf) begin
            if (!b[4]) return a << amt;
            r = a >> amt;
            if (b[5] && a[DW-1]) r = r | ~({DW{1'b1}} >> amt);
            return r;
        end
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, t, act, exp);
        end
    endtask

    // Predict this cycle's outputs from the model and compare.
    task automatic settle_check();
        logic [N-1:0] rdy;
        logic         can;
        #1;
        for (int i = 0; i < N; i++) rdy[i] = st_busy[i] & st_jv[i] & st_kv[i];
        exp_vis = (q.size() > 0) && (q[0].issue + 2 <= t);
        can = !flush && (rdy != '0) && (q.size() < 2 || (cdb_grant && exp_vis));
        exp_clr = '0;
        if (can) begin
            for (int i = N-1; i >= 0; i--) if (rdy[i]) exp_clr = N'(1) << i;
        end
        chk("clr_busy", 32'(rs_clr_busy), 32'(exp_clr));
        chk("cdb_valid", 32'(cdb_valid), 32'(exp_vis));
        if (exp_vis) begin
            chk("cdb_tag", 32'(cdb_tag), 32'(q[0].tag));
            chk("cdb_data", 32'(cdb_data), 32'(q[0].data));
        end
    endtask

    // Advance the model across one clock edge.
    task automatic advance();
        logic         f;
        logic [N-1:0] clr;
        f   = flush;
        clr = exp_clr;
        if (f) begin
            q.delete();
        end else begin
            if (exp_vis && cdb_grant) void'(q.pop_front());
            for (int i = 0; i < N; i++)
                if (clr[i]) q.push_back('{st_dest[i], model_alu(st_op[i], st_vj[i], st_vk[i]), t});
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (f || clr[i]) st_busy[i] = 1'b0;
        @(negedge clk);
        t++;
    endtask

    task automatic clear_st();
        for (int i = 0; i < N; i++) begin
            st_busy[i] = 1'b0; st_jv[i] = 1'b0; st_kv[i] = 1'b0;
            st_op[i] = '0; st_vj[i] = '0; st_vk[i] = '0; st_dest[i] = '0;
        end
    endtask

    task automatic set_st(input int i, input logic [3:0] op, input logic [DW-1:0] vj,
                          input logic [DW-1:0] vk, input logic [TW-1:0] dest);
        st_busy[i] = 1'b1; st_jv[i] = 1'b1; st_kv[i] = 1'b1;
        st_op[i] = op; st_vj[i] = vj; st_vk[i] = vk; st_dest[i] = dest;
    endtask

    task automatic drain(input int n);
        clear_st();
        cdb_grant = 1'b1;
        flush = 1'b0;
        repeat (n) begin
            settle_check();
            advance();
        end
    endtask

    function automatic logic [3:0] rand_op();
        case ($urandom_range(0, 4))
            0: return op_add;
            1: return op_and;
            2: return op_not;
            3: return op_shf;
            default: return 4'($urandom);
        endcase
    endfunction

    task automatic rand_stations();
        for (int i = 0; i < N; i++) begin
            if (!st_busy[i]) begin
                st_jv[i]   = 1'($urandom_range(0, 1));
                st_kv[i]   = 1'($urandom_range(0, 1));
                st_op[i]   = rand_op();
                st_vj[i]   = DW'($urandom);
                st_vk[i]   = DW'($urandom);
                st_dest[i] = TW'($urandom);
                if ($urandom_range(0, 2) == 0) st_busy[i] = 1'b1;
            end else begin
                if ($urandom_range(0, 2) == 0) st_jv[i] = 1'b1;
                if ($urandom_range(0, 2) == 0) st_kv[i] = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        cdb_grant = 1'b0;
        clear_st();
        set_st(0, op_add, 16'h0001, 16'h0001, 3'd1);
        #2;
        chk("reset_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("reset_cdb_tag", 32'(cdb_tag), 32'd0);
        chk("reset_cdb_data", 32'(cdb_data), 32'd0);
        chk("reset_clr_busy", 32'(rs_clr_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_st();

        // Model pinned against hand-computed shift results.
        chk("model_asr", 32'(model_alu(op_shf, 16'h8004, 16'h0032)), 32'h0000E001);
        chk("model_lsr", 32'(model_alu(op_shf, 16'h8004, 16'h0012)), 32'h00002001);
        chk("model_lsl", 32'(model_alu(op_shf, 16'h8004, 16'h0002)), 32'h00000010);

        // Single add through the pipe.
        cdb_grant = 1'b1;
        set_st(1, op_add, 16'h0005, 16'h0003, 3'd2);
        settle_check(); chk("single_clr", 32'(rs_clr_busy), 32'b010); advance();
        settle_check(); advance();
        settle_check();
        chk("single_valid", 32'(cdb_valid), 32'd1);
        chk("single_tag", 32'(cdb_tag), 32'd2);
        chk("single_data", 32'(cdb_data), 32'h0008);
        advance();
        settle_check(); chk("single_clear", 32'(cdb_valid), 32'd0); advance();
        drain(1);

        // Fixed priority: entry 0 before entry 2.
        set_st(0, op_and, 16'hF0F0, 16'hFF00, 3'd5);
        set_st(2, op_not, 16'h1234, 16'h0000, 3'd6);
        settle_check(); chk("prio_first", 32'(rs_clr_busy), 32'b001); advance();
        settle_check(); chk("prio_second", 32'(rs_clr_busy), 32'b100); advance();
        settle_check(); chk("prio_res0", 32'(cdb_data), 32'hF000); advance();
        settle_check(); chk("prio_res1", 32'(cdb_data), 32'hEDCB); advance();
        drain(2);

        // Backpressure with three ready entries.
        set_st(0, op_add, 16'h0001, 16'h0002, 3'd1);
        set_st(1, op_add, 16'h0003, 16'h0004, 3'd3);
        set_st(2, op_and, 16'h00FF, 16'h0F0F, 3'd4);
        cdb_grant = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle_check();
            if (c >= 2) chk("bp_no_issue", 32'(rs_clr_busy), 32'd0);
            advance();
        end
        cdb_grant = 1'b1;
        settle_check();
        chk("bp_issue_on_grant", 32'(rs_clr_busy), 32'b100);
        chk("bp_held_data", 32'(cdb_data), 32'h0003);
        advance();
        drain(4);

        // Shift variants back to back.
        set_st(0, op_shf, 16'h8004, 16'h0032, 3'd0);
        set_st(1, op_shf, 16'h8004, 16'h0012, 3'd1);
        set_st(2, op_shf, 16'h8004, 16'h0002, 3'd2);
        for (int c = 0; c < 5; c++) begin
            settle_check();
            if (c == 2) chk("shf_asr", 32'(cdb_data), 32'hE001);
            if (c == 3) chk("shf_lsr", 32'(cdb_data), 32'h2001);
            if (c == 4) chk("shf_lsl", 32'(cdb_data), 32'h0010);
            advance();
        end
        drain(2);

        // Flush with both stages full and grant high.
        set_st(0, op_add, 16'h0010, 16'h0020, 3'd3);
        set_st(1, op_add, 16'h0030, 16'h0040, 3'd4);
        settle_check(); advance();
        settle_check(); advance();
        set_st(2, op_add, 16'h0001, 16'h0001, 3'd5);
        flush = 1'b1;
        settle_check(); chk("flush_no_clr", 32'(rs_clr_busy), 32'd0); advance();
        flush = 1'b0;
        settle_check(); chk("flush_cdb_drop", 32'(cdb_valid), 32'd0); advance();
        settle_check(); chk("flush_ex_drop", 32'(cdb_valid), 32'd0); advance();
        drain(1);

        // Asynchronous reset between edges with a result on the bus.
        cdb_grant = 1'b0;
        set_st(0, op_add, 16'h0007, 16'h0008, 3'd4);
        settle_check(); advance();
        settle_check(); advance();
        set_st(1, op_add, 16'h0001, 16'h0001, 3'd1);
        settle_check();
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(cdb_valid), 32'd0);
        chk("arst_tag", 32'(cdb_tag), 32'd0);
        chk("arst_data", 32'(cdb_data), 32'd0);
        chk("arst_clr", 32'(rs_clr_busy), 32'd0);
        q.delete();
        clear_st();
        @(negedge clk);
        rst = 1'b0;
        t++;

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            rand_stations();
            cdb_grant = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 39) == 0);
            settle_check();
            advance();
        end
        drain(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
